// File: rtl/gcd_pkg.sv
// Shared types and helpers for the time-shared GCD scheduler.
package gcd_pkg;

  // Scheduler FSM states. IDLE is the reset state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } gcd_state_e;

  // Width of a requester index. It is at least one bit, so a single requester still has an id port.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gcd_dpath.sv
// Iterative subtractive GCD datapath: one swap-or-subtract step per enabled cycle.
module gcd_dpath #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         done,
  output logic [W-1:0] result
);

  logic [W-1:0] r_a;
  logic [W-1:0] r_b;

  // Load operands, or take one step. Keeping A <= B lets B-A never underflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else if (load) begin
      r_a <= a_in;
      r_b <= b_in;
    end else if (step) begin
      if (r_b < r_a) begin
        r_a <= r_b;
        r_b <= r_a;
      end else if (r_a != '0) begin
        r_b <= r_b - r_a;
      end
    end
  end

  // The job is finished once A reaches zero, and B then holds the GCD.
  always_comb begin
    done   = (r_a == '0);
    result = r_b;
  end

endmodule

// File: rtl/gcd_sched.sv
// Round-robin scheduler that shares one GCD datapath among N requesters, one job at a time.
module gcd_sched
  import gcd_pkg::*;
#(
  parameter  int W  = 16,
  parameter  int N  = 4,
  localparam int IW = id_width(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_val,
  output logic [N-1:0]   req_rdy,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic           resp_val,
  input  logic           resp_rdy,
  output logic [W-1:0]   resp_gcd,
  output logic [IW-1:0]  resp_id,
  output logic           busy
);

  gcd_state_e    r_state;
  gcd_state_e    w_nxt_state;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_id;

  logic [IW-1:0] w_gnt_idx;
  logic          w_gnt_any;
  int            w_rr;
  logic          w_load;
  logic          w_step;
  logic          w_done;
  logic [W-1:0]  w_result;

  // Round-robin search from r_ptr. Scanning from the far end lets the nearest requester win.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_rr      = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_rr = int'(r_ptr) + k;
      if (w_rr >= N) w_rr = w_rr - N;
      if (req_val[w_rr]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = IW'(w_rr);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt_state;
  end

  // Next-state logic. DONE waits for the consumer, and the return to IDLE causes a one-cycle bubble.
  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      ST_IDLE: if (w_gnt_any) w_nxt_state = ST_CALC;
      ST_CALC: if (w_done)    w_nxt_state = ST_DONE;
      ST_DONE: if (resp_rdy)  w_nxt_state = ST_IDLE;
      default:                w_nxt_state = ST_IDLE;
    endcase
  end

  // Output decode. Response fields are held at zero outside DONE.
  always_comb begin
    req_rdy  = '0;
    w_load   = 1'b0;
    w_step   = 1'b0;
    resp_val = 1'b0;
    resp_gcd = '0;
    resp_id  = '0;
    busy     = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_any) begin
          req_rdy[w_gnt_idx] = 1'b1;
          w_load             = 1'b1;
        end
      end
      ST_CALC: w_step = 1'b1;
      ST_DONE: begin
        resp_val = 1'b1;
        resp_gcd = w_result;
        resp_id  = r_id;
      end
      default: ;
    endcase
  end

  // Owner tracking. The owner is latched on accept, and the pointer moves past it when its result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id  <= '0;
      r_ptr <= '0;
    end else begin
      if (w_load) r_id <= w_gnt_idx;
      if (r_state == ST_DONE && resp_rdy)
        r_ptr <= (r_id == IW'(N - 1)) ? '0 : r_id + 1'b1;
    end
  end

  gcd_dpath #(.W(W)) u_dpath (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_load),
    .step   (w_step),
    .a_in   (req_a[w_gnt_idx*W +: W]),
    .b_in   (req_b[w_gnt_idx*W +: W]),
    .done   (w_done),
    .result (w_result)
  );

endmodule

// File: tb/tb_gcd_sched.sv
// Randomized self-checking bench for gcd_sched against a Euclid/round-robin reference model.
module tb_gcd_sched;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int TMO = 2000;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_val, req_rdy;
  logic [N*W-1:0] req_a, req_b;
  logic           resp_val, resp_rdy;
  logic [W-1:0]   resp_gcd;
  logic [IW-1:0]  resp_id;
  logic           busy;

  int n_chk = 0;
  int n_err = 0;
  int m_ptr = 0;

  always #5 clk = ~clk;

  gcd_sched #(.W(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_val(req_val), .req_rdy(req_rdy),
    .req_a(req_a), .req_b(req_b), .resp_val(resp_val), .resp_rdy(resp_rdy),
    .resp_gcd(resp_gcd), .resp_id(resp_id), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int ref_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N*W-1:0] lane(input int i, input logic [W-1:0] v);
    logic [N*W-1:0] r;
    r = '0;
    r[i*W +: W] = v;
    return r;
  endfunction

  // Drive junk on the request side so a job in flight can be shown to ignore it.
  task automatic garble();
    req_val = N'($urandom);
    req_a   = {$urandom, $urandom};
    req_b   = {$urandom, $urandom};
  endtask

  // Call at a negedge. Presents a request, checks the grant, and lets the accept edge pass.
  task automatic accept(input logic [N-1:0] v, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                        output int g);
    logic [N-1:0] exp_rdy;
    req_val = v; req_a = a; req_b = b;
    #1;
    g = ref_grant(v, m_ptr);
    exp_rdy = (g < 0) ? '0 : (N'(1) << g);
    chk("req_rdy", req_rdy, exp_rdy);
    @(posedge clk); @(negedge clk);
    garble();
  endtask

  // Wait for the result, check it, optionally stall the consumer, then release it.
  task automatic finish(input int g, input logic [W-1:0] exp_gcd, input int exp_lat, input int stall);
    int lat = 0;
    bit bad = 0;
    logic [W-1:0]  g0;
    logic [IW-1:0] i0;
    #1;
    while (!resp_val && lat < TMO) begin
      if (req_rdy != '0 || !busy) bad = 1;
      @(posedge clk); @(negedge clk);
      lat++;
      garble();
      #1;
    end
    chk("timeout", lat < TMO, 1);
    chk("calc_busy", bad, 0);
    if (exp_lat >= 0) chk("latency", lat, exp_lat);
    chk("gcd", resp_gcd, exp_gcd);
    chk("resp_id", resp_id, g);
    g0 = resp_gcd; i0 = resp_id; bad = 0;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); @(negedge clk);
      garble();
      #1;
      if (!resp_val || resp_gcd != g0 || resp_id != i0 || req_rdy != '0 || !busy) bad = 1;
    end
    if (stall > 0) chk("stall_hold", bad, 0);
    resp_rdy = 1'b1; req_val = '0;
    @(posedge clk); @(negedge clk);
    resp_rdy = 1'b0;
    #1;
    chk("bubble", {busy, resp_val}, 2'b00);
    m_ptr = (g + 1) % N;
  endtask

  initial begin
    int g;
    bit bad;
    logic [N-1:0]   v;
    logic [N*W-1:0] a, b;

    rst_n = 1'b0; req_val = '0; req_a = '0; req_b = '0; resp_rdy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_val", resp_val, 0);
    chk("rst_gcd", resp_gcd, 0);
    chk("rst_id", resp_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy0", req_rdy, 0);
    req_val = 4'b0010;
    #1 chk("rst_rdy1", req_rdy, 4'b0010);
    req_val = '0;
    @(negedge clk) rst_n = 1'b1;

    // Every requester is valid with the same job, so grants must rotate.
    for (int j = 0; j < 5; j++) begin
      accept(4'hF, {N{16'd35}}, {N{16'd21}}, g);
      finish(g, 16'd7, -1, 0);
    end

    // Directed latencies.
    accept(4'b0001, lane(0, 16'd12), lane(0, 16'd18), g);
    finish(g, 16'd6, 6, 0);
    accept(4'b0100, lane(2, 16'd0), lane(2, 16'd0), g);
    finish(g, 16'd0, 1, 0);
    accept(4'b0100, lane(2, 16'd0), lane(2, 16'd7), g);
    finish(g, 16'd7, 1, 0);
    accept(4'b0100, lane(2, 16'd7), lane(2, 16'd0), g);
    finish(g, 16'd7, 2, 0);

    // The consumer stalls for five cycles while the result is held.
    accept(4'b0010, lane(1, 16'd35), lane(1, 16'd21), g);
    finish(g, 16'd7, -1, 5);

    // Random masks, operands and consumer stalls.
    for (int j = 0; j < 30; j++) begin
      v = N'($urandom_range(1, 15));
      a = '0; b = '0;
      for (int i = 0; i < N; i++) begin
        a[i*W +: W] = W'($urandom_range(0, 255));
        b[i*W +: W] = W'($urandom_range(0, 255));
      end
      accept(v, a, b, g);
      finish(g, ref_gcd(a[g*W +: W], b[g*W +: W]), -1, $urandom_range(0, 3));
    end

    // Reset in the middle of a long job discards it and restarts arbitration at requester 0.
    accept(4'b0010, lane(1, 16'd5), lane(1, 16'd10), g);
    finish(g, 16'd5, -1, 0);
    accept(4'b0100, lane(2, 16'd1), lane(2, 16'd65535), g);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_val", resp_val, 0);
    chk("mid_rst_gcd", resp_gcd, 0);
    chk("mid_rst_id", resp_id, 0);
    m_ptr = 0;
    @(negedge clk);
    rst_n = 1'b1; req_val = '0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      #1 if (resp_val || busy) bad = 1;
    end
    chk("no_resp_after_rst", bad, 0);
    accept(4'hF, {N{16'd9}}, {N{16'd6}}, g);
    finish(g, 16'd3, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
